ucsbece154b_line_fill: RTL and testbench



---
 rtl/ucsbece154b_line_fill.sv | 102 ++++++++++
 tb/tb_ucsbece154b_line_fill.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ucsbece154b_line_fill.sv
// rtl/ucsbece154b_line_fill.sv - miss-path line fill: pops refill beats, assembles the line critical-word-first
module ucsbece154b_line_fill #(
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = 4,
  localparam int OFFSET_W   = $clog2(BLOCK_WORDS)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic [OFFSET_W-1:0]               req_offset_i,
  input  logic [DATA_WIDTH-1:0]             fifo_data_i,
  input  logic                              fifo_valid_i,
  output logic                              fifo_pop_o,
  output logic                              crit_valid_o,
  output logic [DATA_WIDTH-1:0]             crit_data_o,
  output logic                              line_valid_o,
  output logic [DATA_WIDTH*BLOCK_WORDS-1:0] line_data_o,
  output logic                              busy_o
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  localparam logic [OFFSET_W:0] BLOCK_CNT = (OFFSET_W+1)'(BLOCK_WORDS);
  localparam logic [OFFSET_W:0] LAST_CNT  = (OFFSET_W+1)'(BLOCK_WORDS-1);

  state_t                                   state_q;
  logic [OFFSET_W-1:0]                      offset_q;
  logic [OFFSET_W:0]                        pop_cnt_q;
  logic [OFFSET_W:0]                        rcv_cnt_q;
  logic                                     pop_q;
  logic                                     crit_valid_q;
  logic [DATA_WIDTH-1:0]                    crit_data_q;
  logic                                     line_valid_q;
  logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0]   line_q;
  logic [OFFSET_W-1:0]                      wr_idx;

  assign busy_o       = (state_q != IDLE);
  assign req_ready_o  = (state_q == IDLE) && !flush_i;
  assign fifo_pop_o   = (state_q == FILL) && fifo_valid_i && (pop_cnt_q < BLOCK_CNT) && !flush_i;
  assign crit_valid_o = crit_valid_q;
  assign crit_data_o  = crit_data_q;
  assign line_valid_o = line_valid_q;
  assign line_data_o  = line_q;

  // Offset wraps naturally at OFFSET_W bits, giving critical-word-first placement.
  assign wr_idx = offset_q + rcv_cnt_q[OFFSET_W-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      offset_q     <= '0;
      pop_cnt_q    <= '0;
      rcv_cnt_q    <= '0;
      pop_q        <= 1'b0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
      line_valid_q <= 1'b0;
      line_q       <= '0;
    end else begin
      pop_q        <= fifo_pop_o;
      crit_valid_q <= 1'b0;
      line_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            offset_q  <= req_offset_i;
            pop_cnt_q <= '0;
            rcv_cnt_q <= '0;
            state_q   <= FILL;
          end
        end
        FILL: begin
          if (flush_i) begin
            state_q <= IDLE;
          end else begin
            if (fifo_pop_o) pop_cnt_q <= pop_cnt_q + 1'b1;
            // fifo_data_i is only meaningful the cycle after a pop.
            if (pop_q) begin
              line_q[wr_idx] <= fifo_data_i;
              rcv_cnt_q      <= rcv_cnt_q + 1'b1;
              if (rcv_cnt_q == '0) begin
                crit_data_q  <= fifo_data_i;
                crit_valid_q <= 1'b1;
              end
              if (rcv_cnt_q == LAST_CNT) begin
                state_q      <= DONE;
                line_valid_q <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ucsbece154b_line_fill.sv
// tb/tb_ucsbece154b_line_fill.sv - randomized bench for the line fill stage against a queue-based FIFO/line model
module tb_ucsbece154b_line_fill;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int OW = 2;
  localparam int LW = DW * BW;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          flush_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [OW-1:0] req_offset_i;
  logic [DW-1:0] fifo_data_i;
  logic          fifo_valid_i;
  logic          fifo_pop_o;
  logic          crit_valid_o;
  logic [DW-1:0] crit_data_o;
  logic          line_valid_o;
  logic [LW-1:0] line_data_o;
  logic          busy_o;

  ucsbece154b_line_fill #(.DATA_WIDTH(DW), .BLOCK_WORDS(BW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_offset_i(req_offset_i),
    .fifo_data_i(fifo_data_i), .fifo_valid_i(fifo_valid_i), .fifo_pop_o(fifo_pop_o),
    .crit_valid_o(crit_valid_o), .crit_data_o(crit_data_o),
    .line_valid_o(line_valid_o), .line_data_o(line_data_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            gate_pct = 100;
  bit            pop_prev = 1'b0;
  logic [DW-1:0] fq[$];
  logic          o_pop, o_crit, o_line, o_ready, o_busy;
  logic [DW-1:0] o_cdat;
  logic [LW-1:0] o_ldat;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: the FIFO model hands out the word popped last cycle, then outputs are sampled.
  task automatic cycle(input logic req, input logic flush);
    @(negedge clk_i);
    cyc++;
    if (pop_prev) fifo_data_i = (fq.size() > 0) ? fq.pop_front() : '0;
    else          fifo_data_i = $urandom;
    fifo_valid_i = (fq.size() > 0) && ($urandom_range(0, 99) < gate_pct);
    req_valid_i  = req;
    flush_i      = flush;
    #1;
    o_pop   = fifo_pop_o;
    o_crit  = crit_valid_o;
    o_line  = line_valid_o;
    o_ready = req_ready_o;
    o_busy  = busy_o;
    o_cdat  = crit_data_o;
    o_ldat  = line_data_o;
    chk("pop_without_valid", LW'(o_pop & ~fifo_valid_i), '0);
    pop_prev = o_pop;
  endtask

  task automatic fill_q(input int n);
    for (int i = 0; i < n; i++) fq.push_back($urandom);
  endtask

  task automatic do_fill(input int off, input int gpct, input int flush_pops);
    logic [DW-1:0] ew[BW];
    logic [LW-1:0] eline;
    int acc, fp, lp, npop, ncrit, ccyc, nline, lcyc, fcyc, guard, start_sz;
    logic [DW-1:0] cdat;
    logic [LW-1:0] ldat;
    logic          ready_after;
    bit            done, fl;
    gate_pct = gpct;
    eline = '0;
    start_sz = fq.size();
    for (int i = 0; i < BW; i++) begin
      ew[i] = (i < fq.size()) ? fq[i] : '0;
      eline[((off + i) % BW) * DW +: DW] = ew[i];
    end
    req_offset_i = OW'(off);
    guard = 0;
    do begin
      cycle(1'b1, 1'b0);
      guard++;
    end while (!o_ready && guard < 20);
    chk("accept", LW'(o_ready), LW'(1));
    acc = cyc;
    fp = -1; lp = -1; npop = 0; ncrit = 0; ccyc = -1; nline = 0; lcyc = -1; fcyc = -1;
    cdat = '0; ldat = '0; ready_after = 1'b0; done = 0; guard = 0;
    while (!done && guard < 400) begin
      guard++;
      fl = (flush_pops >= 0) && (npop == flush_pops) && (fcyc < 0);
      cycle((flush_pops < 0) ? 1'($urandom_range(0, 1)) : 1'b0, fl);
      if (fl) begin
        fcyc = cyc;
        chk("flush_blocks_pop", LW'(o_pop), '0);
      end
      if (fcyc >= 0 && cyc == fcyc + 1) ready_after = o_ready;
      chk("ready_while_busy", LW'(o_ready & o_busy), '0);
      if (o_pop) begin
        if (npop == 0) fp = cyc;
        lp = cyc;
        npop++;
      end
      if (o_crit) begin
        ncrit++;
        ccyc = cyc;
        cdat = o_cdat;
      end
      if (o_line) begin
        nline++;
        lcyc = cyc;
        ldat = o_ldat;
        chk("busy_in_done", LW'(o_busy), LW'(1));
      end
      if (flush_pops < 0) done = (nline > 0);
      else                done = (fcyc >= 0) && (cyc >= fcyc + 3);
    end
    chk("no_timeout", LW'(done), LW'(1));
    if (flush_pops < 0) begin
      chk("pop_count", LW'(npop), LW'(BW));
      chk("crit_count", LW'(ncrit), LW'(1));
      chk("crit_data", LW'(cdat), LW'(ew[0]));
      chk("crit_latency", LW'(ccyc - fp), LW'(2));
      chk("line_count", LW'(nline), LW'(1));
      chk("line_latency", LW'(lcyc - lp), LW'(2));
      chk("line_data", ldat, eline);
      if (gpct == 100) begin
        chk("first_pop_cycle", LW'(fp - acc), LW'(1));
        chk("line_cycle", LW'(lcyc - acc), LW'(BW + 2));
      end
      cycle(1'b0, 1'b0);
      chk("ready_after_line", LW'(o_ready), LW'(1));
      chk("line_pulse_end", LW'(o_line), '0);
      chk("idle_not_busy", LW'(o_busy), '0);
      chk("fifo_residue", LW'(fq.size()), LW'(start_sz - BW));
    end else begin
      chk("flush_pop_count", LW'(npop), LW'(flush_pops));
      chk("flush_no_line", LW'(nline), '0);
      chk("flush_crit", LW'(ncrit), LW'((npop > 0 && fcyc >= fp + 2) ? 1 : 0));
      if (ncrit > 0) chk("flush_crit_data", LW'(cdat), LW'(ew[0]));
      chk("flush_ready_next", LW'(ready_after), LW'(1));
      fq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int off;
    rst_ni = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0; req_offset_i = '0;
    fifo_data_i = '0; fifo_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_pop", LW'(fifo_pop_o), '0);
    chk("rst_line_valid", LW'(line_valid_o), '0);
    chk("rst_crit_valid", LW'(crit_valid_o), '0);
    chk("rst_busy", LW'(busy_o), '0);
    chk("rst_line_data", line_data_o, '0);
    chk("rst_crit_data", LW'(crit_data_o), '0);
    rst_ni = 1'b1;
    cycle(1'b0, 1'b0);
    chk("ready_after_reset", LW'(o_ready), LW'(1));

    // In-order fill, then a wrapped critical-word-first fill
    fq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    do_fill(0, 100, -1);
    fq = '{32'h10, 32'h11, 32'h12, 32'h13};
    do_fill(2, 100, -1);

    // Sparse FIFO availability
    fill_q(4);
    do_fill(1, 33, -1);

    // Surplus entries survive and feed the next request
    fq = '{32'h50, 32'h51, 32'h52, 32'h53, 32'h54, 32'h55};
    do_fill(0, 100, -1);
    chk("surplus_left", LW'(fq.size()), LW'(2));
    fq.push_back(32'h56);
    fq.push_back(32'h57);
    do_fill(3, 100, -1);

    // Flush after two pops, then flush in the critical-word capture cycle
    fill_q(4);
    do_fill(0, 100, 2);
    fill_q(4);
    do_fill(1, 100, 1);

    // Flush in IDLE blocks acceptance for that cycle only
    fill_q(4);
    cycle(1'b1, 1'b1);
    chk("idle_flush_ready", LW'(o_ready), '0);
    cycle(1'b0, 1'b0);
    chk("idle_flush_not_taken", LW'(o_busy), '0);
    do_fill(2, 100, -1);

    // Asynchronous reset mid-fill
    fill_q(4);
    gate_pct = 100;
    req_offset_i = 2'd1;
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    #1 rst_ni = 1'b0;
    #1;
    chk("async_rst_pop", LW'(fifo_pop_o), '0);
    chk("async_rst_busy", LW'(busy_o), '0);
    chk("async_rst_line_data", line_data_o, '0);
    chk("async_rst_crit_data", LW'(crit_data_o), '0);
    @(posedge clk_i);
    #1;
    chk("async_rst_hold_line_valid", LW'(line_valid_o | crit_valid_o), '0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    pop_prev = 1'b0;
    fq.delete();
    fill_q(4);
    do_fill(3, 100, -1);

    // Randomized fills
    for (int n = 0; n < 10; n++) begin
      if (fq.size() < BW) fill_q(BW - fq.size() + $urandom_range(0, 2));
      off = $urandom_range(0, BW - 1);
      do_fill(off, $urandom_range(25, 100), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
